// File: rtl/char_convert.sv
// char_convert: MIX CHAR-instruction datapath.
// Converts the binary magnitude of rA into ten MIX character codes using a
// sequential shift-add-3 (double dabble) converter. It consumes one input
// bit per clock. The control unit pulses start and collects out1 on done.
module char_convert #(
  parameter int NBITS = 30,
  parameter int NDIG  = 10,
  parameter int CBASE = 30
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [6*NDIG-1:0]   in1,
  output logic [6*NDIG-1:0]   out1,
  output logic                busy,
  output logic                done
);

  localparam int CW = $clog2(NBITS);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [NBITS-1:0]    shift_q, shift_d;
  logic [4*NDIG-1:0]   bcd_q, bcd_d;
  logic [CW-1:0]       count_q, count_d;
  logic [6*NDIG-1:0]   out1_q, out1_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  logic [4*NDIG-1:0]   bcdAdj;
  logic [4*NDIG-1:0]   bcdShift;
  logic [6*NDIG-1:0]   charCodes;

  // The sign and upper operand bits take no part in the conversion.
  logic unusedUpperBits;
  assign unusedUpperBits = ^in1[6*NDIG-1:NBITS];

  // Apply the add-3 correction to each BCD digit, then shift in the next
  // binary bit. Also form the character codes of the shifted result.
  always_comb begin
    bcdAdj    = bcd_q;
    charCodes = '0;
    for (int i = 0; i < NDIG; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) begin
        bcdAdj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
    end
    bcdShift = {bcdAdj[4*NDIG-2:0], shift_q[NBITS-1]};
    for (int i = 0; i < NDIG; i++) begin
      charCodes[6*i +: 6] = 6'(CBASE) + {2'b00, bcdShift[4*i +: 4]};
    end
  end

  // Next-state logic: load on start, shift NBITS times, then pulse done.
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    bcd_d   = bcd_q;
    count_d = count_q;
    out1_d  = out1_q;
    busy_d  = busy_q;
    done_d  = done_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          shift_d = in1[NBITS-1:0];
          bcd_d   = '0;
          count_d = '0;
          busy_d  = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        bcd_d   = bcdShift;
        shift_d = {shift_q[NBITS-2:0], 1'b0};
        count_d = count_q + CW'(1);
        if (count_q == CW'(NBITS - 1)) begin
          out1_d  = charCodes;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = DONE;
        end
      end
      DONE: begin
        done_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register. An asynchronous reset discards any partial result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      shift_q <= '0;
      bcd_q   <= '0;
      count_q <= '0;
      out1_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      bcd_q   <= bcd_d;
      count_q <= count_d;
      out1_q  <= out1_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign out1 = out1_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_char_convert.sv
// tb_char_convert: directed checks of the char_convert binary-to-MIX-char converter.
module tb_char_convert;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [59:0] in1;
  logic [59:0] out1;
  logic        busy;
  logic        done;

  int asserts  = 0;
  int failures = 0;

  char_convert dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .in1   (in1),
    .out1  (out1),
    .busy  (busy),
    .done  (done)
  );

  // Free-running 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Pack ten character codes, most significant digit first.
  function automatic logic [59:0] codes(input int c9, input int c8, input int c7,
                                        input int c6, input int c5, input int c4,
                                        input int c3, input int c2, input int c1,
                                        input int c0);
    return {6'(c9), 6'(c8), 6'(c7), 6'(c6), 6'(c5),
            6'(c4), 6'(c3), 6'(c2), 6'(c1), 6'(c0)};
  endfunction

  // One comparison, counted, with a FAIL report on mismatch.
  task automatic checkOutput(input string tag, input logic [59:0] obs, input logic [59:0] exp);
    asserts++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive the request inputs (called just after a falling edge).
  task automatic applyStimulus(input logic s, input logic [59:0] v);
    start = s;
    in1   = v;
  endtask

  // Run one conversion from a single-cycle start pulse and check its timing and result.
  task automatic runConv(input string tag, input logic [59:0] val, input logic [59:0] exp);
    int  lat;
    int  busyCnt;
    bit  seen;
    applyStimulus(1'b1, val);
    @(negedge clk);
    start   = 1'b0;
    lat     = 0;
    busyCnt = 0;
    seen    = 1'b0;
    for (int j = 0; j < 100; j++) begin
      if (done === 1'b1) begin
        seen = 1'b1;
        break;
      end
      if (busy === 1'b1) busyCnt++;
      lat++;
      @(negedge clk);
    end
    checkOutput({tag, "_done_seen"}, 60'(seen), 60'd1);
    checkOutput({tag, "_latency"}, 60'(lat), 60'd30);
    checkOutput({tag, "_busy_cycles"}, 60'(busyCnt), 60'd30);
    checkOutput({tag, "_busy_at_done"}, 60'(busy), 60'd0);
    checkOutput({tag, "_out1"}, out1, exp);
    @(negedge clk);
    checkOutput({tag, "_done_one_cycle"}, 60'(done), 60'd0);
    checkOutput({tag, "_out1_hold"}, out1, exp);
  endtask

  // Directed test sequence.
  initial begin
    logic [59:0] prevExp;
    logic [59:0] expHeld;
    int          doneCnt;
    int          lat;

    rst_n = 1'b0;
    applyStimulus(1'b0, 60'd0);
    repeat (2) @(negedge clk);
    checkOutput("reset_out1", out1, 60'd0);
    checkOutput("reset_busy", 60'(busy), 60'd0);
    checkOutput("reset_done", 60'(done), 60'd0);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("idle_busy", 60'(busy), 60'd0);

    runConv("v53797643", 60'd53797643, codes(30, 30, 35, 33, 37, 39, 37, 36, 34, 33));
    runConv("v0", 60'd0, codes(30, 30, 30, 30, 30, 30, 30, 30, 30, 30));
    runConv("vmax", 60'd1073741823, codes(31, 30, 37, 33, 37, 34, 31, 38, 32, 33));
    runConv("upper_ignored", {30'h3FFF_FFFF, 30'd9}, codes(30, 30, 30, 30, 30, 30, 30, 30, 30, 39));
    prevExp = codes(30, 39, 39, 39, 39, 39, 39, 39, 39, 39);
    runConv("v999999999", 60'd999999999, prevExp);

    // Start held for three edges and pulsed again mid-conversion: one conversion only.
    expHeld = codes(30, 30, 30, 31, 32, 33, 34, 35, 36, 37);
    applyStimulus(1'b1, 60'd1234567);
    @(negedge clk);
    doneCnt = 0;
    lat     = -1;
    for (int j = 0; j < 45; j++) begin
      if (j == 2)  start = 1'b0;
      if (j == 10) start = 1'b1;
      if (j == 11) start = 1'b0;
      if (j == 5) checkOutput("held_out1_kept", out1, prevExp);
      if (done === 1'b1) begin
        doneCnt++;
        if (lat < 0) lat = j;
      end
      @(negedge clk);
    end
    checkOutput("held_done_pulses", 60'(doneCnt), 60'd1);
    checkOutput("held_latency", 60'(lat), 60'd30);
    checkOutput("held_out1", out1, expHeld);
    checkOutput("held_idle_busy", 60'(busy), 60'd0);

    // Asynchronous reset in the middle of a conversion.
    applyStimulus(1'b1, 60'd53797643);
    @(negedge clk);
    start = 1'b0;
    repeat (14) @(negedge clk);
    checkOutput("mid_busy_before_reset", 60'(busy), 60'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("mid_reset_busy", 60'(busy), 60'd0);
    checkOutput("mid_reset_done", 60'(done), 60'd0);
    checkOutput("mid_reset_out1", out1, 60'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    runConv("after_reset_v0", 60'd0, codes(30, 30, 30, 30, 30, 30, 30, 30, 30, 30));

    $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
    $finish;
  end

endmodule
